// File: rtl/double_addsub_serial.sv
// Digit-serial handshaked o = (+/-a) + (+/-b) mod 2^WIDTH, one DIGIT-wide slice per cycle.
// Define DOUBLE_ADDSUB_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module double_addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             negate_a,
    input  logic             negate_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    if ((WIDTH % DIGIT) != 0 || DIGIT == 0) begin : g_bad_digit
        $error("DIGIT must be nonzero and divide WIDTH");
    end

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [DIGIT+1:0] sum;

`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
`endif

    // Carry can reach 2 because both negations inject their +1 at the first digit.
    assign sum = {2'b00, x_q[DIGIT-1:0]} + {2'b00, y_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        o_d     = o_q;
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = a ^ {WIDTH{negate_a}};
                    y_d     = b ^ {WIDTH{negate_b}};
                    carry_d = {1'b0, negate_a} + {1'b0, negate_b};
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                x_d     = x_q >> DIGIT;
                y_d     = y_q >> DIGIT;
                carry_d = sum[DIGIT+1:DIGIT];
                cnt_d   = cnt_q + CntW'(1);
                acc_d[32'(cnt_q) * DIGIT +: DIGIT] = sum[DIGIT-1:0];
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    o_d     = acc_d;
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
                    // Extra sign-extended bit differs from the result MSB on overflow.
                    ovf_d   = x_q[DIGIT-1] ^ y_q[DIGIT-1] ^ sum[DIGIT] ^ sum[DIGIT-1];
`endif
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            o_q     <= '0;
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign o         = o_q;
`ifdef DOUBLE_ADDSUB_SERIAL_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
